// File: rtl/mem_bist.sv
// mem_bist: memory built-in self-test engine.
// Takes over the memory port while busy, runs a mode-selected sequence of
// pattern/march elements, reads every word back and reports pass/fail with
// the first failing address and data.
// Optional build macro BIST_ERR_COUNT_EN: adds a saturating err_cnt output
// and lets the test run to completion instead of aborting on a mismatch.
//
// Handshake: start is a single-cycle request, accepted only when the engine
// is in IDLE (ignored otherwise); done is a one-cycle completion strobe and
// pass/fail_addr/fail_data stay valid from done until the next accepted start.
module mem_bist #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef BIST_ERR_COUNT_EN
  output logic [ADDR_W+1:0] err_cnt,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WT, S_DONE} state_t;

  // Data pattern kinds used by the element table.
  localparam logic [2:0] K_ZERO = 3'd0;
  localparam logic [2:0] K_ONE  = 3'd1;
  localparam logic [2:0] K_55   = 3'd2;
  localparam logic [2:0] K_AA   = 3'd3;
  localparam logic [2:0] K_ADR  = 3'd4;
  localparam logic [2:0] K_CB   = 3'd5;

  localparam logic [1:0] WT_LAST = 2'(READ_LAT - 1);

`ifdef BIST_ERR_COUNT_EN
  localparam bit ABORT = 1'b0;
`else
  localparam bit ABORT = 1'b1;
`endif

  // One element of a test: optional read (compare), optional write, direction.
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       down;
    logic       last;
    logic [2:0] rk;
    logic [2:0] wk;
  } elem_t;

  function automatic logic [DATA_W-1:0] alt_pat(input logic lsb);
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0) ? lsb : ~lsb;
    return p;
  endfunction

  localparam logic [DATA_W-1:0] P55 = alt_pat(1'b1);
  localparam logic [DATA_W-1:0] PAA = alt_pat(1'b0);

  function automatic logic [DATA_W-1:0] pat(input logic [2:0] k, input logic [ADDR_W-1:0] a);
    case (k)
      K_ONE:   return '1;
      K_55:    return P55;
      K_AA:    return PAA;
      K_ADR:   return DATA_W'(a);
      K_CB:    return a[0] ? PAA : P55;
      default: return '0;
    endcase
  endfunction

  // Element table: mode 3 is march C- (W0 up; R0,W1 up; R1,W0 down; R0 up).
  function automatic elem_t desc(input logic [1:0] m, input logic [1:0] e);
    elem_t d;
    d = '0;
    case ({m, e})
      4'b00_00: begin d.wr = 1'b1; d.wk = K_55; end
      4'b00_01: begin d.rd = 1'b1; d.rk = K_55; end
      4'b00_10: begin d.wr = 1'b1; d.wk = K_AA; end
      4'b00_11: begin d.rd = 1'b1; d.rk = K_AA; d.last = 1'b1; end
      4'b01_00: begin d.wr = 1'b1; d.wk = K_ADR; end
      4'b01_01: begin d.rd = 1'b1; d.rk = K_ADR; d.last = 1'b1; end
      4'b10_00: begin d.wr = 1'b1; d.wk = K_CB; end
      4'b10_01: begin d.rd = 1'b1; d.rk = K_CB; d.last = 1'b1; end
      4'b11_00: begin d.wr = 1'b1; d.wk = K_ZERO; end
      4'b11_01: begin d.rd = 1'b1; d.rk = K_ZERO; d.wr = 1'b1; d.wk = K_ONE; end
      4'b11_10: begin d.rd = 1'b1; d.rk = K_ONE; d.wr = 1'b1; d.wk = K_ZERO; d.down = 1'b1; end
      4'b11_11: begin d.rd = 1'b1; d.rk = K_ZERO; d.last = 1'b1; end
      default:  d.last = 1'b1;
    endcase
    return d;
  endfunction

  state_t              state, state_n, adv_state;
  logic [ADDR_W-1:0]   addr, addr_n, adv_addr;
  logic [1:0]          elem, elem_n, adv_elem;
  logic [1:0]          wt_cnt, wt_n;
  logic [1:0]          mode_q;
  logic                err_seen;
  elem_t               cur, nxt;
  logic                go, at_end, cmp_slot, mism;
  logic [DATA_W-1:0]   exp_rd;

  assign go       = (state == S_IDLE) && start;
  assign cur      = desc(mode_q, elem);
  assign nxt      = desc(mode_q, elem + 2'd1);
  assign at_end   = cur.down ? (addr == '0) : (addr == '1);
  assign cmp_slot = (state == S_WT) && (wt_cnt == WT_LAST);
  assign exp_rd   = pat(cur.rk, addr);
  assign mism     = cmp_slot && (mem_rdata != exp_rd);

  // State register plus address/element/wait counters; mode latched on start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      addr   <= '0;
      elem   <= '0;
      wt_cnt <= '0;
      mode_q <= '0;
    end else begin
      state  <= state_n;
      addr   <= addr_n;
      elem   <= elem_n;
      wt_cnt <= wt_n;
      if (go) mode_q <= mode;
    end
  end

  // Next state: step address within an element, wrap only between elements.
  always_comb begin
    adv_state = S_WR;
    adv_addr  = addr;
    adv_elem  = elem;
    if (at_end) begin
      if (cur.last) begin
        adv_state = S_DONE;
      end else begin
        adv_elem  = elem + 2'd1;
        adv_addr  = nxt.down ? '1 : '0;
        adv_state = nxt.rd ? S_RD : S_WR;
      end
    end else begin
      adv_addr  = cur.down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
      adv_state = cur.rd ? S_RD : S_WR;
    end

    state_n = state;
    addr_n  = addr;
    elem_n  = elem;
    wt_n    = wt_cnt;
    case (state)
      S_IDLE: if (start) begin
        state_n = S_WR;
        addr_n  = '0;
        elem_n  = '0;
        wt_n    = '0;
      end
      S_WR: begin
        state_n = adv_state;
        addr_n  = adv_addr;
        elem_n  = adv_elem;
      end
      S_RD: begin
        state_n = S_WT;
        wt_n    = '0;
      end
      S_WT: begin
        if (wt_cnt == WT_LAST) begin
          if (mism && ABORT) begin
            state_n = S_DONE;
          end else if (cur.wr) begin
            state_n = S_WR;
          end else begin
            state_n = adv_state;
            addr_n  = adv_addr;
            elem_n  = adv_elem;
          end
        end else begin
          wt_n = wt_cnt + 2'd1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs decoded from state; write data only driven in write slots.
  always_comb begin
    busy      = (state == S_WR) || (state == S_RD) || (state == S_WT);
    done      = (state == S_DONE);
    mem_en    = busy;
    mem_we    = (state == S_WR);
    mem_addr  = addr;
    mem_wdata = (state == S_WR) ? pat(cur.wk, addr) : '0;
    dbg_state = state;
  end

  // Result capture: first mismatch, error count, pass on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass      <= 1'b0;
      err_seen  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef BIST_ERR_COUNT_EN
      err_cnt   <= '0;
`endif
    end else if (go) begin
      pass      <= 1'b0;
      err_seen  <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
`ifdef BIST_ERR_COUNT_EN
      err_cnt   <= '0;
`endif
    end else begin
      if (mism) begin
        err_seen <= 1'b1;
        if (!err_seen) begin
          fail_addr <= addr;
          fail_data <= mem_rdata;
        end
`ifdef BIST_ERR_COUNT_EN
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
      end
      if ((state_n == S_DONE) && (state != S_DONE)) pass <= !(err_seen || mism);
    end
  end

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: two engines (READ_LAT 1 and 2, 16 words) on behavioural
// memories with stuck-at masks. Run expectations are queued at start and
// checked by a monitor on each done pulse.
module tb_mem_bist;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;
  localparam int EW = 53;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_start, a_busy, a_done, a_pass, a_en, a_we;
  logic [1:0]    a_mode;
  logic [AW-1:0] a_faddr, a_addr;
  logic [DW-1:0] a_fdata, a_wdata, a_rdata;
  logic [2:0]    a_dbg;
  logic          b_start, b_busy, b_done, b_pass, b_en, b_we;
  logic [1:0]    b_mode;
  logic [AW-1:0] b_faddr, b_addr;
  logic [DW-1:0] b_fdata, b_wdata, b_rdata, b_p1;
  logic [2:0]    b_dbg;
`ifdef BIST_ERR_COUNT_EN
  logic [AW+1:0] a_err, b_err;
`endif

  mem_bist #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .busy(a_busy), .done(a_done),
    .pass(a_pass), .fail_addr(a_faddr), .fail_data(a_fdata), .mem_en(a_en), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
`ifdef BIST_ERR_COUNT_EN
    .err_cnt(a_err),
`endif
    .dbg_state(a_dbg));

  mem_bist #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .busy(b_busy), .done(b_done),
    .pass(b_pass), .fail_addr(b_faddr), .fail_data(b_fdata), .mem_en(b_en), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
`ifdef BIST_ERR_COUNT_EN
    .err_cnt(b_err),
`endif
    .dbg_state(b_dbg));

  // Memory A: latency 1, stuck-at-0 mask applied on write, tracks highest read address.
  logic [DW-1:0] mem_a[N];
  logic [DW-1:0] stuck_a[N];
  logic [AW-1:0] a_max_rd;
  always @(posedge clk) begin
    if (a_en && a_we) mem_a[a_addr] <= a_wdata & ~stuck_a[a_addr];
    a_rdata <= mem_a[a_addr];
    if (a_start && !a_busy) a_max_rd <= '0;
    else if (a_en && !a_we && (a_addr > a_max_rd)) a_max_rd <= a_addr;
  end

  // Memory B: latency 2, logs write addresses of the current run.
  logic [DW-1:0] mem_b[N];
  logic [AW-1:0] wlog_b[64];
  logic [6:0]    b_wcnt = '0;
  always @(posedge clk) begin
    if (b_en && b_we) begin
      mem_b[b_addr] <= b_wdata;
      if (!b_wcnt[6]) wlog_b[b_wcnt[5:0]] <= b_addr;
      b_wcnt <= b_wcnt + 7'd1;
    end
    if (b_start && !b_busy) b_wcnt <= '0;
    b_p1    <= mem_b[b_addr];
    b_rdata <= b_p1;
  end

  int checks = 0;
  int errors = 0;
  int a_bcnt = 0;
  int b_bcnt = 0;
  bit tb_done = 1'b0;
  logic [EW-1:0] exp_qa[$];
  logic [EW-1:0] exp_qb[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [EW-1:0] mk(input int cyc, input logic p, input logic [AW-1:0] fa,
                                        input logic [DW-1:0] fd);
    return {16'(cyc), p, fa, fd};
  endfunction

  function automatic void check_run(input string name, input logic [EW-1:0] e, input int cnt,
                                    input logic p, input logic [AW-1:0] fa, input logic [DW-1:0] fd);
    check({name, "_busy_cycles"}, 64'(cnt), 64'(e[52:37]));
    check({name, "_pass"}, 64'(p), 64'(e[36]));
    if (!e[36]) begin
      check({name, "_fail_addr"}, 64'(fa), 64'(e[35:32]));
      check({name, "_fail_data"}, 64'(fd), 64'(e[31:0]));
    end
  endfunction

  // Monitor: count busy cycles, check each done against the queued expectation.
  task automatic mon_step();
    if (!rst) begin
      a_bcnt = 0;
      b_bcnt = 0;
    end
    if (a_busy) a_bcnt++;
    if (b_busy) b_bcnt++;
    if (a_done) begin
      if (exp_qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: actual done=1 required no run pending");
      end else check_run("a", exp_qa.pop_front(), a_bcnt, a_pass, a_faddr, a_fdata);
      a_bcnt = 0;
    end
    if (b_done) begin
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: actual done=1 required no run pending");
      end else check_run("b", exp_qb.pop_front(), b_bcnt, b_pass, b_faddr, b_fdata);
      b_bcnt = 0;
    end
  endtask

  task automatic go(input bit on_b, input logic [1:0] m);
    @(negedge clk);
    if (on_b) begin b_mode = m; b_start = 1'b1; end
    else begin a_mode = m; a_start = 1'b1; end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit on_b, input string name);
    int n = 0;
    while (!(on_b ? b_done : a_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(on_b ? b_done : a_done)) begin
      checks++; errors++;
      $display("FAIL %s_timeout: actual no done after %0d cycles required done", name, n);
    end
    @(negedge clk);
  endtask

  task automatic wait_busy_a(input int k);
    int n = 0;
    while (a_bcnt < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (a_bcnt < k) begin
      checks++; errors++;
      $display("FAIL wait_busy_a: actual %0d busy cycles required %0d", a_bcnt, k);
    end
  endtask

  task automatic run_tests();
    // Reset state
    #2 rst = 1'b0;
    #10;
    check("rst_busy", 64'(a_busy), 0);
    check("rst_done", 64'(a_done), 0);
    check("rst_pass", 64'(a_pass), 0);
    check("rst_mem_en", 64'(a_en), 0);
    check("rst_mem_we", 64'(a_we), 0);
    check("rst_mem_addr", 64'(a_addr), 0);
    check("rst_mem_wdata", 64'(a_wdata), 0);
    check("rst_fail_addr", 64'(a_faddr), 0);
    check("rst_fail_data", 64'(a_fdata), 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Address-as-data, fault free
    exp_qa.push_back(mk(48, 1'b1, 4'd0, 32'd0));
    go(1'b0, 2'd1);
    wait_done(1'b0, "t1");
    check("t1_pass_hold", 64'(a_pass), 1);
    for (int i = 0; i < N; i++) check($sformatf("t1_mem%0d", i), 64'(mem_a[i]), 64'(i));

    // Bit 3 of word 9 stuck at 0: abort after reading word 9
    stuck_a[9] = 32'h0000_0008;
    exp_qa.push_back(mk(36, 1'b0, 4'd9, 32'h0000_0001));
    go(1'b0, 2'd1);
    wait_done(1'b0, "t2");
    check("t2_max_read_addr", 64'(a_max_rd), 9);
    stuck_a[9] = '0;

    // Words 3 and 12 stuck at 0
    stuck_a[3]  = '1;
    stuck_a[12] = '1;
`ifdef BIST_ERR_COUNT_EN
    exp_qa.push_back(mk(48, 1'b0, 4'd3, 32'd0));
`else
    exp_qa.push_back(mk(24, 1'b0, 4'd3, 32'd0));
`endif
    go(1'b0, 2'd1);
    wait_done(1'b0, "t6");
`ifdef BIST_ERR_COUNT_EN
    check("t6_err_cnt", 64'(a_err), 2);
`else
    check("t6_max_read_addr", 64'(a_max_rd), 3);
`endif
    stuck_a[3]  = '0;
    stuck_a[12] = '0;

    // Solid patterns
    exp_qa.push_back(mk(96, 1'b1, 4'd0, 32'd0));
    go(1'b0, 2'd0);
    wait_done(1'b0, "m0");
    for (int i = 0; i < N; i += 5) check($sformatf("m0_mem%0d", i), 64'(mem_a[i]), 64'h0000_0000_AAAA_AAAA);

    // March C- at latency 1
    exp_qa.push_back(mk(144, 1'b1, 4'd0, 32'd0));
    go(1'b0, 2'd3);
    wait_done(1'b0, "m3a");
    check("m3a_mem7", 64'(mem_a[7]), 0);

    // March C- at latency 2, R1W0 element must walk addresses downwards
    exp_qb.push_back(mk(192, 1'b1, 4'd0, 32'd0));
    go(1'b1, 2'd3);
    wait_done(1'b1, "t3");
    check("t3_write_count", 64'(b_wcnt), 48);
    for (int i = 0; i < N; i++) check($sformatf("t3_mem%0d", i), 64'(mem_b[i]), 0);
    for (int i = 0; i < N; i++) check($sformatf("t3_down_addr%0d", i), 64'(wlog_b[32 + i]), 64'(15 - i));

    // Address-as-data at latency 2
    exp_qb.push_back(mk(64, 1'b1, 4'd0, 32'd0));
    go(1'b1, 2'd1);
    wait_done(1'b1, "m1b");
    check("m1b_mem13", 64'(mem_b[13]), 13);

    // Reset mid-run: outputs drop before the next edge
    go(1'b0, 2'd2);
    wait_busy_a(10);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("t4_busy", 64'(a_busy), 0);
    check("t4_mem_we", 64'(a_we), 0);
    check("t4_mem_en", 64'(a_en), 0);
    check("t4_pass", 64'(a_pass), 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_qa.push_back(mk(48, 1'b1, 4'd0, 32'd0));
    go(1'b0, 2'd2);
    wait_done(1'b0, "t4");
    for (int i = 0; i < N; i++)
      check($sformatf("t4_mem%0d", i), 64'(mem_a[i]), (i % 2 == 1) ? 64'hAAAA_AAAA : 64'h5555_5555);

    // Second start while busy with a different mode is ignored
    exp_qa.push_back(mk(48, 1'b1, 4'd0, 32'd0));
    go(1'b0, 2'd1);
    wait_busy_a(5);
    a_mode  = 2'd0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_done(1'b0, "t5");
    for (int i = 0; i < N; i++) check($sformatf("t5_mem%0d", i), 64'(mem_a[i]), 64'(i));

    check("end_qa_empty", 64'(exp_qa.size()), 0);
    check("end_qb_empty", 64'(exp_qb.size()), 0);
    tb_done = 1'b1;
  endtask

  initial begin
    a_start = 1'b0; a_mode = 2'd0;
    b_start = 1'b0; b_mode = 2'd0;
    for (int i = 0; i < N; i++) stuck_a[i] = '0;
    fork
      begin
        while (!tb_done) begin
          @(negedge clk);
          mon_step();
        end
      end
      run_tests();
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
Parametrised built-in self-test engine for the data memory. It generalises the single store-then-load check into full-array pattern and march tests. It takes over the memory port via `mem_en`, writes a mode-selected pattern, reads every word back and compares it, then reports pass/fail with the first failing address and data. It sits beside the data memory and is muxed onto its port while `busy`.

Parameters:
- DATA_W, 32, memory word width in bits.
- ADDR_W, 8, word-address width; array depth N = 2**ADDR_W.
- READ_LAT, 1, memory read latency in cycles (1..4); `mem_rdata` is valid READ_LAT cycles after the address is presented.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  0=solid (0x55.. pass then 0xAA.. pass), 1=address-as-data, 2=checkerboard, 3=march.
- busy  out  1  test running.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid from done until next start; 1 = no mismatch.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_data  out  DATA_W  data read at first mismatch.
- mem_en  out  1  BIST owns the memory port (equals busy).
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, mem_en, mem_we = 0; pass = 0; fail_addr, fail_data, mem_addr, mem_wdata = 0. It takes effect immediately, including mid-test; no memory write is completed after rst falls.
- FSM states: IDLE, WR, RD, WT, DONE.
  - IDLE: start=1 latches mode and goes to the first element; busy=1 from the next cycle.
  - WR: one write per cycle, mem_we=1.
  - RD: drive the address with mem_we=0, then enter WT.
  - WT: count READ_LAT cycles; in the last WT cycle compare mem_rdata to expected. Each read therefore costs 1+READ_LAT cycles.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Data pattern per mode:
  - mode 0: element W(0x55..) up, R up, W(0xAA..) up, R up.
  - mode 1: data = address, zero-extended to DATA_W; W up, R up.
  - mode 2: data = a[0] ? 0xAA.. : 0x55..; W up, R up.
  - mode 3 (march C-): W0 up; R0,W1 up; R1,W0 down; R0 up.
    - Read-modify elements issue the write in the cycle after the compare, so they cost 2+READ_LAT cycles per address.
- Up order runs 0..N-1; down order runs N-1..0. The address counter wraps only at element boundaries; the end of the last element goes to DONE.
- Mismatch: first mismatch captures fail_addr/fail_data, clears pass, and goes straight to DONE (abort).
- Completion without mismatch: pass=1 at done.
- Outputs while idle: mem_we=0 whenever not in WR or a write slot.
- start while busy: ignored.
- start in the DONE cycle: ignored.
- mode changes while busy: have no effect.
- Busy cycle counts for N=16, READ_LAT=1:
  - mode 1: 16 + 32 = 48.
  - mode 0: 96.
  - mode 3: 16 + 48 + 48 + 32 = 144.

Optional Feature:
- Macro: BIST_ERR_COUNT_EN.
- With the macro defined:
  - Adds output err_cnt [ADDR_W+1:0], saturating, cleared at start.
  - A mismatch does not abort; the test runs to completion.
  - fail_addr/fail_data hold the first mismatch; pass = (err_cnt==0).
- Without the macro: no err_cnt port; the test aborts at the first mismatch.

Test Plan:
1. Fault-free model, ADDR_W=4, READ_LAT=1, mode 1, start pulse -> busy high exactly 48 cycles, done pulse, pass=1, memory[a]=a afterwards.
2. Model forces bit 3 of word 9 to 0, mode 1 -> done after the read of addr 9, pass=0, fail_addr=9, fail_data=0x00000001, no reads beyond addr 9.
3. Fault-free, READ_LAT=2, mode 3 -> busy 16+64+64+48=192 cycles, pass=1, all words 0 at end; mem_addr descends 15..0 during R1,W0.
4. mode 2 run; pull rst low at busy cycle 10 -> busy, mem_we, mem_en 0 in the same cycle (before the next edge); a later start runs a full test to pass=1.
5. start pulsed again at busy cycle 5 with mode changed to 0 -> ignored; the cycle count and pattern match the original mode.
6. BIST_ERR_COUNT_EN defined, stuck-at-0 on words 3 and 12, mode 1 -> full 48-cycle run, err_cnt=2, fail_addr=3, pass=0.
